// File: rtl/appr_err_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
// APPR_ERR_SQ_EN (see top level) is the only consumer of sat_add.
package appr_err_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 32;
    localparam int ACC_W_DEF = 64;
    localparam int SAT_W     = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Adds two values and clamps the result to the all-ones value of an acc_w-bit register.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] add,
        input int unsigned      acc_w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, acc} + {1'b0, add};
        lim = (SAT_W+1)'(1) << acc_w;
        if (sum >= lim) begin
            sum = lim - (SAT_W+1)'(1);
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/appr_error_monitor_if.sv
// Valid/ready pair channel carrying (approx, exact) adder results into the monitor.
interface appr_error_monitor_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] approx;
    logic signed [WIDTH-1:0] exact;

    modport master (output in_valid, output approx, output exact, input in_ready);
    modport slave  (input in_valid, input approx, input exact, output in_ready);
endinterface

// File: rtl/appr_err_stage.sv
// Stage 1: signed difference, magnitude and nonzero flag of one accepted pair.
module appr_err_stage #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic signed [WIDTH-1:0] approx,
    input  logic signed [WIDTH-1:0] exact,
    output logic                    vld_p1,
    output logic signed [WIDTH:0]   diff_p1,
    output logic [WIDTH:0]          abs_p1,
    output logic                    nz_p1
);

    logic signed [WIDTH:0] diff_p1_d, diff_p1_q;
    logic [WIDTH:0]        abs_p1_d, abs_p1_q;
    logic                  nz_p1_d, nz_p1_q;
    logic                  vld_p1_q;

    // One extra bit makes the difference exact; -2^WIDTH negates to 2^WIDTH unsigned.
    always_comb begin
        diff_p1_d = $signed({approx[WIDTH-1], approx}) - $signed({exact[WIDTH-1], exact});
        abs_p1_d  = diff_p1_d[WIDTH] ? $unsigned(-diff_p1_d) : $unsigned(diff_p1_d);
        nz_p1_d   = |diff_p1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld) begin
            diff_p1_q <= diff_p1_d;
            abs_p1_q  <= abs_p1_d;
            nz_p1_q   <= nz_p1_d;
        end
    end

    assign vld_p1  = vld_p1_q;
    assign diff_p1 = diff_p1_q;
    assign abs_p1  = abs_p1_q;
    assign nz_p1   = nz_p1_q;

endmodule

// File: rtl/appr_error_monitor.sv
// Error-statistics collector: run FSM, sample counter and stage-2 accumulators.
// Define APPR_ERR_SQ_EN to build the squarer and err_sq_sum; otherwise err_sq_sum is 0.
module appr_error_monitor
    import appr_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    appr_error_monitor_if.slave     bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic signed [ACC_W-1:0] err_sum,
    output logic [ACC_W-1:0]        err_sq_sum,
    output logic [WIDTH:0]          max_abs_err
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic                  in_ready_q, in_ready_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic                  clr;
    logic                  accept;

    logic                  vld_p1;
    logic signed [WIDTH:0] diff_p1;
    logic [WIDTH:0]        abs_p1;
    logic                  nz_p1;

    logic                  vld_p2_q;
    logic signed [WIDTH:0] diff_p2_q;
    logic [WIDTH:0]        abs_p2_q;
    logic                  nz_p2_q;

    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic signed [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [WIDTH:0]          max_q, max_d;

    assign accept       = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;

    appr_err_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (accept),
        .approx  (bus.approx),
        .exact   (bus.exact),
        .vld_p1  (vld_p1),
        .diff_p1 (diff_p1),
        .abs_p1  (abs_p1),
        .nz_p1   (nz_p1)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        in_ready_d   = in_ready_q;
        sample_cnt_d = sample_cnt_q;
        clr          = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d          = num_samples;
                    clr          = 1'b1;
                    sample_cnt_d = '0;
                    if (num_samples == '0) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d    = RUN;
                        in_ready_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_cnt_d == n_q) begin
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last pair has left both pipeline registers once neither valid is set.
                if (!vld_p1 && !vld_p2_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        err_sum_d = err_sum_q;
        max_d     = max_q;
        if (clr) begin
            err_cnt_d = '0;
            err_sum_d = '0;
            max_d     = '0;
        end else if (vld_p2_q) begin
            err_cnt_d = err_cnt_q + CNT_W'(nz_p2_q);
            err_sum_d = err_sum_q + ACC_W'(diff_p2_q);
            if (abs_p2_q > max_q) begin
                max_d = abs_p2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            in_ready_q   <= 1'b0;
            sample_cnt_q <= '0;
            vld_p2_q     <= 1'b0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            in_ready_q   <= in_ready_d;
            sample_cnt_q <= sample_cnt_d;
            vld_p2_q     <= vld_p1;
            err_cnt_q    <= err_cnt_d;
            err_sum_q    <= err_sum_d;
            max_q        <= max_d;
        end
    end

    // ---- stage 2: hold the error one cycle (squaring alongside), then accumulate ----
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            diff_p2_q <= diff_p1;
            abs_p2_q  <= abs_p1;
            nz_p2_q   <= nz_p1;
        end
    end

`ifdef APPR_ERR_SQ_EN
    localparam int SQ_W = 2*WIDTH + 2;
    logic [SQ_W-1:0]  sq_p2_q;
    logic [ACC_W-1:0] sq_sum_q, sq_sum_d;

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            sq_p2_q <= SQ_W'(abs_p1) * SQ_W'(abs_p1);
        end
    end

    always_comb begin
        sq_sum_d = sq_sum_q;
        if (clr) begin
            sq_sum_d = '0;
        end else if (vld_p2_q) begin
            sq_sum_d = ACC_W'(sat_add(SAT_W'(sq_sum_q), SAT_W'(sq_p2_q), ACC_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_sum_q <= '0;
        end else begin
            sq_sum_q <= sq_sum_d;
        end
    end

    assign err_sq_sum = sq_sum_q;
`else
    assign err_sq_sum = '0;
`endif

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign err_sum     = err_sum_q;
    assign max_abs_err = max_q;

endmodule

// File: tb/tb_appr_error_monitor.sv
// Self-checking bench for appr_error_monitor: vector table plus per-pair scoreboard.
module tb_appr_error_monitor;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [31:0]         num;
    logic                busy, done;
    logic [31:0]         sample_cnt, err_cnt;
    logic signed [63:0]  err_sum;
    logic [63:0]         err_sq_sum;
    logic [32:0]         max_abs_err;

    appr_error_monitor_if #(.WIDTH(32)) bus ();

    appr_error_monitor #(.WIDTH(32), .CNT_W(32), .ACC_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .err_sum     (err_sum),
        .err_sq_sum  (err_sq_sum),
        .max_abs_err (max_abs_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] x;
        longint             sum;
        int unsigned        cnt;
        logic [32:0]        mx;
        logic [63:0]        sq;
    } vec_t;

    typedef struct {
        int first;
        int n;
        bit gap;
    } run_t;

    typedef struct {
        int          due;
        longint      sum;
        int unsigned cnt;
        logic [32:0] mx;
        logic [63:0] sq;
    } sb_t;

    vec_t tbl[6];
    run_t runs[4];
    sb_t  sbq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    bit start_honor = 1'b0;

    longint      m_sum;
    int unsigned m_cnt;
    int unsigned m_samp;
    logic [32:0] m_max;
    logic [63:0] m_sq;

    function automatic logic [63:0] sqx(input logic [63:0] v);
`ifdef APPR_ERR_SQ_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sum = 0; m_cnt = 0; m_samp = 0; m_max = '0; m_sq = '0;
    endtask

    task automatic model_add(input logic signed [31:0] a, input logic signed [31:0] x);
        longint      e;
        logic [32:0] ab;
        logic [65:0] s;
        e  = longint'(a) - longint'(x);
        ab = (e < 0) ? 33'(-e) : 33'(e);
        m_sum = m_sum + e;
        if (e != 0) m_cnt++;
        if (ab > m_max) m_max = ab;
        s = 66'(m_sq) + 66'(ab) * 66'(ab);
        m_sq = sqx((s > 66'h0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0]);
    endtask

    // One clock: update the model for what the edge will do, then sample 1 ns after it.
    task automatic do_cycle();
        bit acc;
        acc = bus.in_valid && bus.in_ready && !rst;
        if (rst) begin
            model_clear();
            sbq.delete();
        end else if (start && start_honor) begin
            model_clear();
        end
        if (acc) begin
            model_add(bus.approx, bus.exact);
            m_samp++;
            sbq.push_back('{cyc + 3, m_sum, m_cnt, m_max, m_sq});
            last_acc = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("sample_cnt", 64'(sample_cnt), 64'(m_samp));
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_err_sum", err_sum, e.sum);
            chk("sb_err_cnt", 64'(err_cnt), 64'(e.cnt));
            chk("sb_max_abs_err", 64'(max_abs_err), 64'(e.mx));
            chk("sb_err_sq_sum", err_sq_sum, e.sq);
        end
    endtask

    task automatic pulse_start(input logic [31:0] n, input bit honor);
        start = 1'b1; num = n; start_honor = honor;
        do_cycle();
        start = 1'b0; num = 32'hDEAD_BEEF;
    endtask

    task automatic send(input logic signed [31:0] a, input logic signed [31:0] x);
        bit took;
        int i;
        bus.in_valid = 1'b1; bus.approx = a; bus.exact = x;
        took = 1'b0;
        for (i = 0; i < 20 && !took; i++) begin
            took = bus.in_ready;
            do_cycle();
        end
        if (!took) chk("send_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done && i < 20) begin
            do_cycle();
            i++;
        end
        chk("done", 64'(done), 64'd1);
        chk("done_latency", 64'(cyc - last_acc), 64'd3);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic chk_model_final(input int n);
        chk("fin_sample_cnt", 64'(sample_cnt), 64'(n));
        chk("fin_err_sum", err_sum, m_sum);
        chk("fin_err_cnt", 64'(err_cnt), 64'(m_cnt));
        chk("fin_max_abs_err", 64'(max_abs_err), 64'(m_max));
        chk("fin_err_sq_sum", err_sq_sum, m_sq);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_err_sum"}, err_sum, 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_max_abs_err"}, 64'(max_abs_err), 64'd0);
        chk({tag, "_err_sq_sum"}, err_sq_sum, 64'd0);
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int l;
        tbl[0] = '{32'sd10, 32'sd8, 64'sd2, 1, 33'd2, 64'd4};
        tbl[1] = '{32'sd5, 32'sd5, 64'sd2, 1, 33'd2, 64'd4};
        tbl[2] = '{-32'sd3, 32'sd1, -64'sd2, 2, 33'd4, 64'd20};
        tbl[3] = '{32'sd7, 32'sd9, -64'sd4, 3, 33'd4, 64'd24};
        tbl[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1, 33'h0_FFFF_FFFF,
                   64'hFFFF_FFFE_0000_0001};
        tbl[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hFFFF_FFFE_0000_0002, 2, 33'h0_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF};
        runs[0] = '{0, 4, 1'b0};
        runs[1] = '{0, 4, 1'b1};
        runs[2] = '{4, 1, 1'b0};
        runs[3] = '{4, 2, 1'b0};

        model_clear();
        rst = 1'b1; start = 1'b0; num = '0;
        bus.in_valid = 1'b0; bus.approx = '0; bus.exact = '0;
        do_cycle();
        do_cycle();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_zero("rst");
        rst = 1'b0;
        do_cycle();

        for (int r = 0; r < 4; r++) begin
            pulse_start(32'(runs[r].n), 1'b1);
            chk("start_in_ready", 64'(bus.in_ready), 64'd1);
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_done", 64'(done), 64'd0);
            chk_zero("start");
            c0 = cyc;
            for (int j = 0; j < runs[r].n; j++) begin
                send(tbl[runs[r].first + j].a, tbl[runs[r].first + j].x);
                if (runs[r].gap && j < runs[r].n - 1) begin
                    bus.in_valid = 1'b0;
                    do_cycle();
                end
            end
            chk("run_cycles", 64'(cyc - c0), 64'(runs[r].gap ? 2 * runs[r].n - 1 : runs[r].n));
            chk("in_ready_after_last", 64'(bus.in_ready), 64'd0);
            if (runs[r].gap) begin
                bus.in_valid = 1'b1; bus.approx = 32'sd1; bus.exact = 32'sd2;
            end else begin
                bus.in_valid = 1'b0;
            end
            wait_done();
            bus.in_valid = 1'b0;
            l = runs[r].first + runs[r].n - 1;
            chk("tbl_sample_cnt", 64'(sample_cnt), 64'(runs[r].n));
            chk("tbl_err_sum", err_sum, tbl[l].sum);
            chk("tbl_err_cnt", 64'(err_cnt), 64'(tbl[l].cnt));
            chk("tbl_max_abs_err", 64'(max_abs_err), 64'(tbl[l].mx));
            chk("tbl_err_sq_sum", err_sq_sum, sqx(tbl[l].sq));
        end

        // zero-length run from DONE
        pulse_start(32'd0, 1'b1);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk_zero("zero");
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            chk("zero_in_ready", 64'(bus.in_ready), 64'd0);
            chk("zero_done_held", 64'(done), 64'd1);
        end

        // reset in the middle of an N=10 run
        pulse_start(32'd10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send($urandom, ($urandom_range(0, 2) == 0) ? 32'sd0 : $urandom);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk_zero("midrst");
        do_cycle();
        do_cycle();
        chk_zero("midrst_quiet");
        pulse_start(32'd2, 1'b1);
        send(32'sd100, 32'sd40);
        send(-32'sd7, 32'sd0);
        bus.in_valid = 1'b0;
        wait_done();
        chk_model_final(2);

        // start pulse during a run must be ignored
        pulse_start(32'd6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                start = 1'b1; num = 32'd2; start_honor = 1'b0;
            end
            send($urandom, $urandom_range(0, 3));
            start = 1'b0;
            if (i < 5) chk("ign_busy", 64'(busy), 64'd1);
        end
        bus.in_valid = 1'b0;
        wait_done();
        chk_model_final(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
